// File: rtl/serializer.sv
// serializer: wide-to-narrow valid/ready converter, most-significant chunk first.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data[INWIDTH] wide input;
// out_valid/out_ready/out_data[OUTWIDTH] narrow output; out_last marks each word's
// final chunk and exists only when SERIALIZER_LAST_EN is defined.
module serializer #(
  parameter int INLOGBITS  = 6,
  parameter int OUTLOGBITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1<<INLOGBITS)-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef SERIALIZER_LAST_EN
  output logic                        out_last,
`endif
  output logic [(1<<OUTLOGBITS)-1:0]  out_data
);
  localparam int INWIDTH    = 1 << INLOGBITS;
  localparam int OUTWIDTH   = 1 << OUTLOGBITS;
  localparam int LOGBITDIFF = INLOGBITS - OUTLOGBITS;
  localparam logic [LOGBITDIFF-1:0] MAXCNT = '1;
  logic [INWIDTH-1:0]    sreg;
  logic [LOGBITDIFF-1:0] cnt;
  logic                  full;
  logic                  last;
  logic                  in_xfer;
  logic                  out_xfer;
  always_comb begin
    last      = full && cnt == MAXCNT;
    out_valid = full;
    out_data  = sreg[INWIDTH-1 -: OUTWIDTH];
    in_ready  = !full || (cnt == MAXCNT && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = full && out_ready;
  end
`ifdef SERIALIZER_LAST_EN
  assign out_last = last;
`endif
  // A new word wins over the final shift; cnt wraps to 0 on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (in_xfer) begin
      sreg <= in_data;
      cnt  <= '0;
      full <= 1'b1;
    end else if (out_xfer) begin
      sreg <= sreg << OUTWIDTH;
      cnt  <= cnt + 1'b1;
      full <= !last;
    end
  end
endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Width-narrowing stream converter: accepts one wide word on a valid/ready input and emits it as 2^(INLOGBITS-OUTLOGBITS) narrow chunks on a valid/ready output.
- Transmit-side counterpart of the team's deserializer. Emits the most-significant chunk first, so serializer -> deserializer with mirrored parameters reproduces the original word bit-exact.
- Sits between wide internal datapaths (pixel/packet words) and narrow links (camera/byte-lane interfaces).

Parameters:
- INLOGBITS, default 6, log2 of input word width (INWIDTH = 1<<INLOGBITS).
- OUTLOGBITS, default 3, log2 of output chunk width (OUTWIDTH = 1<<OUTLOGBITS); must be strictly less than INLOGBITS.
- Derived constants: LOGBITDIFF = INLOGBITS-OUTLOGBITS; MAXCNT = (1<<LOGBITDIFF)-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle (combinational from registered state and out_ready).
- in_data  input  INWIDTH  input word.
- out_valid  output  1  chunk present (registered).
- out_ready  input  1  downstream accepts chunk.
- out_data  output  OUTWIDTH  current chunk (registered).

Behaviour:
- State: shift register sreg[INWIDTH-1:0], chunk counter cnt[LOGBITDIFF-1:0], flag full.
- out_data = sreg[INWIDTH-1 -: OUTWIDTH]; out_valid = full.
- in_ready = !full || (cnt==MAXCNT && out_ready).
- Transfers: in_xfer = in_valid && in_ready; out_xfer = out_valid && out_ready.
- Reset (rst=1 at clock edge): sreg=0, cnt=0, full=0, so out_valid=0, out_data=0 and in_ready=1 the following cycle. Reset overrides every other event, including a reset mid-word: the partially sent word is discarded, with no residual chunks.
- Per-edge update, in priority order:
  - rst: as above.
  - in_xfer (whether or not a final out_xfer occurs in the same cycle): sreg<=in_data, cnt<=0, full<=1.
  - out_xfer && cnt!=MAXCNT: sreg<=sreg<<OUTWIDTH (zero fill), cnt<=cnt+1.
  - out_xfer && cnt==MAXCNT: full<=0, cnt<=0 (wraps), sreg<=sreg<<OUTWIDTH.
  - Otherwise: hold all state.
- Latency: word accepted at edge N; first chunk valid in the cycle after edge N.
- Throughput: with out_ready held high and in_valid continuous, one chunk per cycle with no bubbles; the next word is accepted in the same cycle as the previous word's last chunk.
- Backpressure: while out_valid && !out_ready, out_data, cnt and sreg are frozen, and in_ready=0 whenever full.
- Empty: out_valid=0 and in_ready=1; out_data holds the zero-shifted residue (deterministic, ignored by consumers).
- in_valid may be asserted or dropped freely while in_ready=0; no data is captured.
- No combinational path from in_valid/in_data to any output. in_ready depends combinationally on out_ready only.

Optional Feature:
- Macro: SERIALIZER_LAST_EN.
- Defined: adds output port out_last (1 bit) = full && cnt==MAXCNT, marking the final chunk of each word. out_last is 0 after reset and is held stable under backpressure.
- Undefined: no out_last port; all other behaviour is identical.

Test Plan:
- Basic order: rst, then in_data=64'h0102030405060708 with in_valid pulsed one cycle and out_ready=1 -> out_data 8'h01,02,03,04,05,06,07,08 on 8 consecutive cycles starting the cycle after accept; out_valid then drops to 0.
- Back-to-back: two words 64'h1111..11 and 64'h2222..22 with in_valid held and out_ready=1 -> 16 consecutive valid chunks with no gap; the second word is accepted in the cycle chunk 8 of the first is transferred (in_ready=1 that cycle).
- Backpressure: drop out_ready for 3 cycles while chunk 8'h04 is presented -> 8'h04 held stable and in_ready=0 throughout; sequence resumes 8'h05 with no chunk lost or duplicated.
- Mid-word reset: assert rst after 3 chunks transferred -> next cycle out_valid=0, out_data=0, in_ready=1; a new word 64'hA0A1..A7 then emits 8'hA0 first.
- Round-trip: random 64-bit words with random in_valid/out_ready into serializer -> deserializer(3,6) -> the deserializer output sequence equals the input sequence.
- SERIALIZER_LAST_EN defined: out_last=1 only on chunk 8'h08 of 64'h0102030405060708, and it holds 1 through 2 cycles of out_ready=0.
